// File: rtl/multi_vend_ctrl.sv
// multi_vend_ctrl -- multi-item vending machine controller.
//
// Accepts coins into a credit register, dispenses one of N_ITEMS products at
// a fixed PRICE, returns change or refunds credit on cancel. All outputs are
// registered.
//
// Optional feature macro: VEND_STOCK_TRACK_EN
//   defined   : per-item stock counters, sold_out flags, restock, and
//               refusal of purchases of sold-out items.
//   undefined : stock is unlimited, sold_out is constant 0, restock ignored.
//
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   coin_valid    coin strobe; coin_code 00=10, 01=50, 10=100, 11=invalid
//   buy, sel      purchase request for item sel
//   cancel        refund all credit
//   restock       reload stock counters (IDLE only)
//   credit        accumulated credit
//   vend, vend_id dispense pulse and item index
//   change_valid, change_amt   change/refund pulse and amount
//   coin_reject   coin returned without crediting
//   deny          purchase refused
//   sold_out      per-item empty flags
//   idle          controller in IDLE
module multi_vend_ctrl #(
   parameter int N_ITEMS    = 4,
   parameter int PRICE      = 300,
   parameter int MAX_CREDIT = 500,
   parameter int CREDIT_W   = 10,
   parameter int STOCK_W    = 4,
   parameter int INIT_STOCK = 10
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       coin_valid,
   input  logic [1:0]                 coin_code,
   input  logic                       buy,
   input  logic [$clog2(N_ITEMS)-1:0] sel,
   input  logic                       cancel,
   input  logic                       restock,
   output logic [CREDIT_W-1:0]        credit,
   output logic                       vend,
   output logic [$clog2(N_ITEMS)-1:0] vend_id,
   output logic                       change_valid,
   output logic [CREDIT_W-1:0]        change_amt,
   output logic                       coin_reject,
   output logic                       deny,
   output logic [N_ITEMS-1:0]         sold_out,
   output logic                       idle
);

   localparam int SEL_W = $clog2(N_ITEMS);
   localparam int CW1   = CREDIT_W + 1;
   localparam logic [CREDIT_W:0] PRICE_C = CW1'(PRICE);
   localparam logic [CREDIT_W:0] MAX_C   = CW1'(MAX_CREDIT);

   typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

   state_t               state_q, state_d;
   logic [CREDIT_W-1:0]  credit_q, credit_d;
   logic                 vend_q, vend_d;
   logic [SEL_W-1:0]     vend_id_q, vend_id_d;
   logic                 chg_vld_q, chg_vld_d;
   logic [CREDIT_W-1:0]  chg_amt_q, chg_amt_d;
   logic                 rej_q, rej_d;
   logic                 deny_q, deny_d;
   logic                 idle_q;
   logic [CREDIT_W:0]    coin_sum;
   logic [CREDIT_W:0]    remainder;
   logic                 sel_ok;
   logic                 sold_sel;

   function automatic logic [CREDIT_W:0] coin_value(input logic [1:0] code);
      case (code)
         2'b00:   return CW1'(10);
         2'b01:   return CW1'(50);
         2'b10:   return CW1'(100);
         default: return '0;
      endcase
   endfunction

   assign coin_sum  = {1'b0, credit_q} + coin_value(coin_code);
   assign remainder = {1'b0, credit_q} - PRICE_C;
   assign sel_ok    = (int'(sel) < N_ITEMS);

`ifdef VEND_STOCK_TRACK_EN
   logic [STOCK_W-1:0] stock_q [N_ITEMS];
   logic [STOCK_W-1:0] stock_d [N_ITEMS];
   logic [N_ITEMS-1:0] sold_q;
   logic               dec_en;
   logic               reload_en;

   assign sold_sel = sel_ok ? sold_q[sel] : 1'b1;

   always_comb begin
      for (int i = 0; i < N_ITEMS; i++) begin
         stock_d[i] = stock_q[i];
         if (reload_en)
            stock_d[i] = STOCK_W'(INIT_STOCK);
         else if (dec_en && (sel == SEL_W'(i)) && (stock_q[i] != '0))
            stock_d[i] = stock_q[i] - 1'b1;   // saturates at zero
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_ITEMS; i++) begin
            stock_q[i] <= STOCK_W'(INIT_STOCK);
            sold_q[i]  <= (INIT_STOCK == 0);
         end
      end else begin
         for (int i = 0; i < N_ITEMS; i++) begin
            stock_q[i] <= stock_d[i];
            sold_q[i]  <= (stock_d[i] == '0);
         end
      end
   end

   assign sold_out = sold_q;
`else
   logic unused_restock;
   assign unused_restock = restock;
   assign sold_sel = 1'b0;
   assign sold_out = '0;
`endif

   always_comb begin
      state_d   = state_q;
      credit_d  = credit_q;
      vend_d    = 1'b0;
      vend_id_d = '0;
      chg_vld_d = 1'b0;
      chg_amt_d = '0;
      rej_d     = 1'b0;
      deny_d    = 1'b0;
`ifdef VEND_STOCK_TRACK_EN
      dec_en    = 1'b0;
      reload_en = 1'b0;
`endif
      case (state_q)
         S_IDLE, S_CREDIT: begin
            // cancel > buy > coin; a cancel in IDLE has nothing to refund and
            // is treated as absent.
            if (cancel && state_q == S_CREDIT) begin
               state_d   = S_CHANGE;
               chg_vld_d = 1'b1;
               chg_amt_d = credit_q;
               credit_d  = '0;
               rej_d     = coin_valid;
            end else if (buy) begin
               if (state_q == S_CREDIT && {1'b0, credit_q} >= PRICE_C &&
                   sel_ok && !sold_sel) begin
                  state_d   = S_VEND;
                  vend_d    = 1'b1;
                  vend_id_d = sel;
`ifdef VEND_STOCK_TRACK_EN
                  dec_en    = 1'b1;
`endif
               end else begin
                  deny_d = 1'b1;
               end
               rej_d = coin_valid;
            end else if (coin_valid) begin
               if (coin_code != 2'b11 && coin_sum <= MAX_C) begin
                  credit_d = coin_sum[CREDIT_W-1:0];
                  state_d  = S_CREDIT;
               end else begin
                  rej_d = 1'b1;
               end
            end
`ifdef VEND_STOCK_TRACK_EN
            if (state_q == S_IDLE && restock)
               reload_en = 1'b1;
`endif
         end
         S_VEND: begin
            // Credit stays visible during VEND and clears on leaving it.
            credit_d = '0;
            rej_d    = coin_valid;
            if ({1'b0, credit_q} > PRICE_C) begin
               state_d   = S_CHANGE;
               chg_vld_d = 1'b1;
               chg_amt_d = remainder[CREDIT_W-1:0];
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin   // S_CHANGE
            state_d = S_IDLE;
            rej_d   = coin_valid;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         credit_q  <= '0;
         vend_q    <= 1'b0;
         vend_id_q <= '0;
         chg_vld_q <= 1'b0;
         chg_amt_q <= '0;
         rej_q     <= 1'b0;
         deny_q    <= 1'b0;
         idle_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         credit_q  <= credit_d;
         vend_q    <= vend_d;
         vend_id_q <= vend_id_d;
         chg_vld_q <= chg_vld_d;
         chg_amt_q <= chg_amt_d;
         rej_q     <= rej_d;
         deny_q    <= deny_d;
         idle_q    <= (state_d == S_IDLE);
      end
   end

   assign credit       = credit_q;
   assign vend         = vend_q;
   assign vend_id      = vend_id_q;
   assign change_valid = chg_vld_q;
   assign change_amt   = chg_amt_q;
   assign coin_reject  = rej_q;
   assign deny         = deny_q;
   assign idle         = idle_q;

endmodule

// File: tb/tb_multi_vend_ctrl.sv
// Self-checking bench for multi_vend_ctrl: directed scenarios against fixed
// expected values, then randomized traffic against a behavioural model.
module tb_multi_vend_ctrl;

   localparam int N_ITEMS    = 4;
   localparam int PRICE      = 300;
   localparam int MAX_CREDIT = 500;
   localparam int CREDIT_W   = 10;
   localparam int STOCK_W    = 4;
   localparam int INIT_STOCK = 10;
   localparam int SEL_W      = $clog2(N_ITEMS);

   logic                clk = 1'b0;
   logic                rst_n;
   logic                coin_valid;
   logic [1:0]          coin_code;
   logic                buy;
   logic [SEL_W-1:0]    sel;
   logic                cancel;
   logic                restock;
   logic [CREDIT_W-1:0] credit;
   logic                vend;
   logic [SEL_W-1:0]    vend_id;
   logic                change_valid;
   logic [CREDIT_W-1:0] change_amt;
   logic                coin_reject;
   logic                deny;
   logic [N_ITEMS-1:0]  sold_out;
   logic                idle;

   int n_tests = 0;
   int n_fail  = 0;

   multi_vend_ctrl #(
      .N_ITEMS(N_ITEMS), .PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT),
      .CREDIT_W(CREDIT_W), .STOCK_W(STOCK_W), .INIT_STOCK(INIT_STOCK)
   ) dut (
      .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_code(coin_code),
      .buy(buy), .sel(sel), .cancel(cancel), .restock(restock),
      .credit(credit), .vend(vend), .vend_id(vend_id),
      .change_valid(change_valid), .change_amt(change_amt),
      .coin_reject(coin_reject), .deny(deny), .sold_out(sold_out), .idle(idle)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
   task automatic tick(input logic cv, input logic [1:0] cc, input logic b,
                       input logic [SEL_W-1:0] s, input logic cn, input logic rs);
      coin_valid = cv; coin_code = cc; buy = b; sel = s; cancel = cn; restock = rs;
      @(posedge clk); #1;
      coin_valid = 1'b0; buy = 1'b0; cancel = 1'b0; restock = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      n_tests++; if (credit !== 0) begin n_fail++; $display("FAIL rst_credit got %0d exp 0", credit); end
      n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle got %b exp 1", idle); end
      n_tests++; if ({vend, change_valid, coin_reject, deny} !== 4'b0) begin
         n_fail++; $display("FAIL rst_pulses got %b exp 0000", {vend, change_valid, coin_reject, deny}); end
      n_tests++; if (change_amt !== 0) begin n_fail++; $display("FAIL rst_change_amt got %0d exp 0", change_amt); end
      n_tests++; if (sold_out !== 0) begin n_fail++; $display("FAIL rst_sold_out got %b exp 0", sold_out); end
      rst_n = 1'b1;
      tick(0, 0, 0, 0, 0, 0);
      n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle_after got %b exp 1", idle); end
   endtask

   task automatic test_basic_vend();
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         tick(1, 2'b10, 0, 0, 0, 0);
         n_tests++; if (credit !== CREDIT_W'(100 * i)) begin
            n_fail++; $display("FAIL basic_credit%0d got %0d exp %0d", i, credit, 100 * i); end
      end
      n_tests++; if (idle !== 1'b0) begin n_fail++; $display("FAIL basic_not_idle got %b exp 0", idle); end
      tick(0, 0, 1, 2, 0, 0);
      n_tests++; if (vend !== 1'b1 || vend_id !== 2) begin
         n_fail++; $display("FAIL basic_vend got vend=%b id=%0d exp 1/2", vend, vend_id); end
      n_tests++; if (change_valid !== 1'b0) begin n_fail++; $display("FAIL basic_nochg0 got %b exp 0", change_valid); end
      tick(0, 0, 0, 0, 0, 0);
      n_tests++; if (idle !== 1'b1 || credit !== 0 || change_valid !== 1'b0 || vend !== 1'b0) begin
         n_fail++; $display("FAIL basic_idle got idle=%b credit=%0d cv=%b vend=%b exp 1/0/0/0",
                            idle, credit, change_valid, vend); end
   endtask

   task automatic test_change();
      do_reset();
      repeat (4) tick(1, 2'b10, 0, 0, 0, 0);
      n_tests++; if (credit !== 400) begin n_fail++; $display("FAIL chg_credit got %0d exp 400", credit); end
      tick(0, 0, 1, 0, 0, 0);
      n_tests++; if (vend !== 1'b1 || vend_id !== 0) begin
         n_fail++; $display("FAIL chg_vend got vend=%b id=%0d exp 1/0", vend, vend_id); end
      tick(0, 0, 0, 0, 0, 0);
      n_tests++; if (change_valid !== 1'b1 || change_amt !== 100 || credit !== 0) begin
         n_fail++; $display("FAIL chg_amt got cv=%b amt=%0d credit=%0d exp 1/100/0",
                            change_valid, change_amt, credit); end
      tick(0, 0, 0, 0, 0, 0);
      n_tests++; if (idle !== 1'b1 || change_valid !== 1'b0 || change_amt !== 0) begin
         n_fail++; $display("FAIL chg_idle got idle=%b cv=%b amt=%0d exp 1/0/0", idle, change_valid, change_amt); end
   endtask

   task automatic test_max_credit();
      do_reset();
      repeat (5) tick(1, 2'b10, 0, 0, 0, 0);
      n_tests++; if (credit !== 500) begin n_fail++; $display("FAIL max_credit got %0d exp 500", credit); end
      tick(1, 2'b00, 0, 0, 0, 0);
      n_tests++; if (coin_reject !== 1'b1 || credit !== 500) begin
         n_fail++; $display("FAIL max_over got rej=%b credit=%0d exp 1/500", coin_reject, credit); end
      tick(1, 2'b11, 0, 0, 0, 0);
      n_tests++; if (coin_reject !== 1'b1 || credit !== 500) begin
         n_fail++; $display("FAIL max_badcode got rej=%b credit=%0d exp 1/500", coin_reject, credit); end
      tick(0, 0, 0, 0, 0, 0);
      n_tests++; if (coin_reject !== 1'b0) begin n_fail++; $display("FAIL max_rej_clear got %b exp 0", coin_reject); end
      tick(0, 0, 0, 0, 1, 0);
      n_tests++; if (change_valid !== 1'b1 || change_amt !== 500 || credit !== 0) begin
         n_fail++; $display("FAIL max_cancel got cv=%b amt=%0d credit=%0d exp 1/500/0",
                            change_valid, change_amt, credit); end
      tick(1, 2'b01, 0, 0, 0, 0);   // coin during CHANGE is returned
      n_tests++; if (coin_reject !== 1'b1 || idle !== 1'b1 || credit !== 0) begin
         n_fail++; $display("FAIL max_coin_in_change got rej=%b idle=%b credit=%0d exp 1/1/0",
                            coin_reject, idle, credit); end
   endtask

   task automatic test_deny_priority();
      do_reset();
      tick(0, 0, 1, 1, 0, 0);
      n_tests++; if (deny !== 1'b1 || idle !== 1'b1) begin
         n_fail++; $display("FAIL deny_idle got deny=%b idle=%b exp 1/1", deny, idle); end
      repeat (2) tick(1, 2'b10, 0, 0, 0, 0);
      tick(0, 0, 1, 1, 0, 0);
      n_tests++; if (deny !== 1'b1 || credit !== 200 || vend !== 1'b0) begin
         n_fail++; $display("FAIL deny_low got deny=%b credit=%0d vend=%b exp 1/200/0", deny, credit, vend); end
      tick(1, 2'b10, 1, 1, 1, 0);
      n_tests++; if (change_valid !== 1'b1 || change_amt !== 200 || coin_reject !== 1'b1 ||
                     vend !== 1'b0 || deny !== 1'b0) begin
         n_fail++; $display("FAIL prio got cv=%b amt=%0d rej=%b vend=%b deny=%b exp 1/200/1/0/0",
                            change_valid, change_amt, coin_reject, vend, deny); end
      tick(0, 0, 0, 0, 0, 0);
      n_tests++; if (idle !== 1'b1 || credit !== 0) begin
         n_fail++; $display("FAIL prio_idle got idle=%b credit=%0d exp 1/0", idle, credit); end
   endtask

   task automatic test_stock();
      do_reset();
      for (int p = 1; p <= 10; p++) begin
         repeat (3) tick(1, 2'b10, 0, 0, 0, 0);
         tick(0, 0, 1, 1, 0, 0);
         n_tests++; if (vend !== 1'b1 || vend_id !== 1) begin
            n_fail++; $display("FAIL stock_vend%0d got vend=%b id=%0d exp 1/1", p, vend, vend_id); end
         tick(0, 0, 0, 0, 0, 0);
`ifdef VEND_STOCK_TRACK_EN
         n_tests++; if (sold_out[1] !== (p == 10)) begin
            n_fail++; $display("FAIL stock_flag%0d got %b exp %b", p, sold_out[1], p == 10); end
`endif
      end
      repeat (3) tick(1, 2'b10, 0, 0, 0, 0);
      tick(0, 0, 1, 1, 0, 0);
`ifdef VEND_STOCK_TRACK_EN
      n_tests++; if (deny !== 1'b1 || vend !== 1'b0 || credit !== 300) begin
         n_fail++; $display("FAIL stock_11th got deny=%b vend=%b credit=%0d exp 1/0/300", deny, vend, credit); end
      tick(0, 0, 0, 0, 1, 0);
      tick(0, 0, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 1);
      n_tests++; if (sold_out !== 0) begin n_fail++; $display("FAIL stock_restock got %b exp 0", sold_out); end
`else
      n_tests++; if (vend !== 1'b1 || deny !== 1'b0 || sold_out !== 0) begin
         n_fail++; $display("FAIL stock_unlimited got vend=%b deny=%b so=%b exp 1/0/0", vend, deny, sold_out); end
      tick(0, 0, 0, 0, 0, 0);
`endif
   endtask

   task automatic test_reset_mid_vend();
      do_reset();
      repeat (4) tick(1, 2'b10, 0, 0, 0, 0);
      tick(0, 0, 1, 3, 0, 0);
      n_tests++; if (vend !== 1'b1 || credit !== 400) begin
         n_fail++; $display("FAIL midrst_vend got vend=%b credit=%0d exp 1/400", vend, credit); end
      #2 rst_n = 1'b0;
      #1;
      n_tests++; if (credit !== 0 || idle !== 1'b1 || vend !== 1'b0 || change_valid !== 1'b0) begin
         n_fail++; $display("FAIL midrst_async got credit=%0d idle=%b vend=%b cv=%b exp 0/1/0/0",
                            credit, idle, vend, change_valid); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick(0, 0, 0, 0, 0, 0);
      n_tests++; if (change_valid !== 1'b0 || change_amt !== 0 || idle !== 1'b1 || sold_out !== 0) begin
         n_fail++; $display("FAIL midrst_after got cv=%b amt=%0d idle=%b so=%b exp 0/0/1/0",
                            change_valid, change_amt, idle, sold_out); end
   endtask

   // Behavioural model: credit amount plus two "busy" flags for the cycle
   // after a sale and the cycle spent paying out.
   int m_credit, m_stock[N_ITEMS];
   bit m_after_sale, m_paying;
   bit e_vend, e_cv, e_rej, e_deny, e_idle;
   int e_id, e_amt;

   task automatic model_step(input bit cv, input int cc, input bit b, input int s,
                             input bit cn, input bit rs);
      int val;
      bit was_idle;
      e_vend = 0; e_cv = 0; e_rej = 0; e_deny = 0; e_id = 0; e_amt = 0;
      val = (cc == 0) ? 10 : (cc == 1) ? 50 : (cc == 2) ? 100 : -1;
      if (m_after_sale) begin
         m_after_sale = 0;
         if (m_credit - PRICE > 0) begin e_cv = 1; e_amt = m_credit - PRICE; m_paying = 1; end
         m_credit = 0;
         e_rej = cv;
      end else if (m_paying) begin
         m_paying = 0;
         e_rej = cv;
      end else begin
         was_idle = (m_credit == 0);
         if (cn && !was_idle) begin
            e_cv = 1; e_amt = m_credit; m_credit = 0; m_paying = 1; e_rej = cv;
         end else if (b) begin
`ifdef VEND_STOCK_TRACK_EN
            if (m_credit >= PRICE && s < N_ITEMS && m_stock[s] > 0) begin
               m_stock[s]--;
`else
            if (m_credit >= PRICE && s < N_ITEMS) begin
`endif
               e_vend = 1; e_id = s; m_after_sale = 1;
            end else e_deny = 1;
            e_rej = cv;
         end else if (cv) begin
            if (val > 0 && m_credit + val <= MAX_CREDIT) m_credit += val;
            else e_rej = 1;
         end
`ifdef VEND_STOCK_TRACK_EN
         if (rs && was_idle) foreach (m_stock[i]) m_stock[i] = INIT_STOCK;
`endif
      end
      e_idle = !m_after_sale && !m_paying && (m_credit == 0);
   endtask

   task automatic test_random();
      logic [N_ITEMS-1:0] e_so;
      bit cv, b, cn, rs;
      int cc, s, r;
      do_reset();
      m_credit = 0; m_after_sale = 0; m_paying = 0;
      foreach (m_stock[i]) m_stock[i] = INIT_STOCK;
      for (int cyc = 0; cyc < 600; cyc++) begin
         r = $urandom_range(0, 11);
         cv = (r < 6); b = (r == 6 || r == 7); cn = (r == 8); rs = (r == 9);
         cc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 2;
         s = $urandom_range(0, N_ITEMS - 1);
         model_step(cv, cc, b, s, cn, rs);
         tick(cv, 2'(cc), b, SEL_W'(s), cn, rs);
         e_so = '0;
`ifdef VEND_STOCK_TRACK_EN
         foreach (m_stock[i]) e_so[i] = (m_stock[i] == 0);
`endif
         n_tests++; if (credit !== CREDIT_W'(m_credit)) begin
            n_fail++; $display("FAIL rnd_credit cyc%0d got %0d exp %0d", cyc, credit, m_credit); end
         n_tests++; if ({vend, change_valid, coin_reject, deny, idle} !== {e_vend, e_cv, e_rej, e_deny, e_idle}) begin
            n_fail++; $display("FAIL rnd_flags cyc%0d got %b exp %b", cyc,
               {vend, change_valid, coin_reject, deny, idle}, {e_vend, e_cv, e_rej, e_deny, e_idle}); end
         n_tests++; if (change_amt !== CREDIT_W'(e_amt)) begin
            n_fail++; $display("FAIL rnd_amt cyc%0d got %0d exp %0d", cyc, change_amt, e_amt); end
         if (e_vend) begin
            n_tests++; if (vend_id !== SEL_W'(e_id)) begin
               n_fail++; $display("FAIL rnd_id cyc%0d got %0d exp %0d", cyc, vend_id, e_id); end
         end
         n_tests++; if (sold_out !== e_so) begin
            n_fail++; $display("FAIL rnd_sold_out cyc%0d got %b exp %b", cyc, sold_out, e_so); end
      end
   endtask

   initial begin
      rst_n = 1'b0; coin_valid = 1'b0; coin_code = 2'b00; buy = 1'b0;
      sel = '0; cancel = 1'b0; restock = 1'b0;
      #3;
      test_reset();
      test_basic_vend();
      test_change();
      test_max_credit();
      test_deny_priority();
      test_stock();
      test_reset_mid_vend();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
